dial_solver: RTL and testbench

// - Consumes the rotation stream from the input skid-buffer stage through a valid/ready handshake.
// - Rotation word: bit[DATA_W-1] = 1 for L (toward lower numbers), 0 for R; bits[DATA_W-2:0] = distance.
// - Tracks a DIAL_SIZE-position dial. part1 counts rotations that end on 0; part2 counts every click that lands on 0.
// - Raises done_o after total_num_turns_i rotations have been processed.

---
 rtl/dial_solver.sv | 167 ++++++++++++++++
 tb/tb_dial_solver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dial_solver.sv
`default_nettype none
// ============================================================================
// Module      : dial_solver
// Description : Rotation-stream dial puzzle solver. Accepts rotation words
//               over valid/ready, removes whole laps one per cycle, then
//               applies the remainder. Counts rotations ending on 0 (part1)
//               and every click landing on 0 (part2).
// Revision    : 1.0 - initial release
// ============================================================================
module dial_solver #(
  parameter int DATA_W    = 16,
  parameter int DIAL_SIZE = 100,
  parameter int START_POS = 50,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic [DATA_W-1:0] total_num_turns_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [CNT_W-1:0]  part1_o,
  output logic [CNT_W-1:0]  part2_o,
  output logic              done_o
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_RUN    = 3'd1;
  localparam logic [2:0] c_REDUCE = 3'd2;
  localparam logic [2:0] c_APPLY  = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  localparam logic [DATA_W-1:0] c_DIAL    = DATA_W'(DIAL_SIZE);
  localparam logic [DATA_W-1:0] c_START   = DATA_W'(START_POS);
  localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

  logic [2:0]        r_state;
  logic              r_ready;
  logic              r_done;
  logic [CNT_W-1:0]  r_part1;
  logic [CNT_W-1:0]  r_part2;
  logic [CNT_W-1:0]  r_turns;
  logic [DATA_W-1:0] r_pos;
  logic [DATA_W-1:0] r_rem;
  logic              r_dir;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_next_pos;
  logic              w_click;
  logic              w_hit_zero;
  logic [CNT_W-1:0]  w_turns_next;
  logic [CNT_W-1:0]  w_total_ext;
  logic              w_last;

  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign part1_o = r_part1;
  assign part2_o = r_part2;

  // Final sub-lap move: next position and whether a click lands on 0.
  // Leaving 0 to the left never lands on 0 because rem < DIAL_SIZE here.
  always_comb begin
    w_sum      = r_pos + r_rem;
    w_next_pos = r_pos;
    w_click    = 1'b0;
    if (!r_dir) begin
      if (w_sum >= c_DIAL) begin
        w_next_pos = w_sum - c_DIAL;
        w_click    = 1'b1;
      end else begin
        w_next_pos = w_sum;
      end
    end else if (r_rem == '0) begin
      w_next_pos = r_pos;
    end else if (r_pos == '0) begin
      w_next_pos = c_DIAL - r_rem;
    end else if (r_rem >= r_pos) begin
      w_click    = 1'b1;
      w_next_pos = (r_rem == r_pos) ? '0 : (r_pos + c_DIAL - r_rem);
    end else begin
      w_next_pos = r_pos - r_rem;
    end
    w_hit_zero = (w_next_pos == '0);
  end

  // Turn bookkeeping for the end-of-APPLY done decision.
  always_comb begin
    w_turns_next = r_turns + c_CNT_ONE;
    w_total_ext  = CNT_W'(total_num_turns_i);
    w_last       = (w_turns_next == w_total_ext);
  end

  // Control FSM and datapath; init_i overrides every state and any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_part1 <= '0;
      r_part2 <= '0;
      r_turns <= '0;
      r_pos   <= c_START;
      r_rem   <= '0;
      r_dir   <= 1'b0;
    end else if (init_i) begin
      r_state <= c_RUN;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_part1 <= '0;
      r_part2 <= '0;
      r_turns <= '0;
      r_pos   <= c_START;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_ready <= 1'b0;
        end
        c_RUN: begin
          if (valid_i && r_ready) begin
            r_dir   <= data_i[DATA_W-1];
            r_rem   <= {1'b0, data_i[DATA_W-2:0]};
            r_ready <= 1'b0;
            r_state <= c_REDUCE;
          end
        end
        c_REDUCE: begin
          if (r_rem >= c_DIAL) begin
            r_rem   <= r_rem - c_DIAL;
            r_part2 <= r_part2 + c_CNT_ONE;
          end else begin
            r_state <= c_APPLY;
          end
        end
        c_APPLY: begin
          r_pos   <= w_next_pos;
          r_turns <= w_turns_next;
          if (w_click) begin
            r_part2 <= r_part2 + c_CNT_ONE;
          end
          if (w_hit_zero) begin
            r_part1 <= r_part1 + c_CNT_ONE;
          end
          if (w_last) begin
            r_state <= c_DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_state <= c_RUN;
            r_ready <= 1'b1;
          end
        end
        c_DONE: begin
          r_ready <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= c_IDLE;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dial_solver.sv
`default_nettype none
// ============================================================================
// Module      : tb_dial_solver
// Description : Scoreboard bench for dial_solver. Expected part1/part2 are
//               queued at stimulus time and popped by a monitor on done_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dial_solver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_i = 1'b0;
  logic [15:0] total_num_turns_i = '0;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] part1_o;
  logic [31:0] part2_o;
  logic        done_o;

  typedef struct {
    longint p1;
    longint p2;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] t5_words[$];

  dial_solver dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .init_i            (init_i),
    .total_num_turns_i (total_num_turns_i),
    .data_i            (data_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .part1_o           (part1_o),
    .part2_o           (part2_o),
    .done_o            (done_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic note_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic logic [15:0] rot_l(input int d);
    return {1'b1, 15'(d)};
  endfunction

  function automatic logic [15:0] rot_r(input int d);
    return {1'b0, 15'(d)};
  endfunction

  task automatic push_exp(input longint p1, input longint p2);
    exp_t e;
    e.p1 = p1;
    e.p2 = p2;
    sb.push_back(e);
  endtask

  // Present a word and hold it until the handshake completes
  task automatic send(input logic [15:0] w);
    int cnt;
    cnt = 0;
    @(negedge clk);
    data_i  = w;
    valid_i = 1'b1;
    while (!ready_o && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (!ready_o) begin
      note_timeout("send");
    end else begin
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic do_init();
    @(negedge clk);
    init_i = 1'b1;
    @(negedge clk);
    init_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    while (!done_o && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    if (!done_o) note_timeout(name);
    @(negedge clk);
  endtask

  // Monitor: each rising done_o consumes one scoreboard entry
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done_o && !prev_done) begin
        if (sb.size() == 0) begin
          note_timeout("sb_unexpected_done");
        end else begin
          e = sb.pop_front();
          chk("sb_part1", longint'(part1_o), e.p1);
          chk("sb_part2", longint'(part2_o), e.p2);
        end
      end
      prev_done = done_o;
    end
  end

  initial begin
    int lat;
    int pos, p1, p2, d;
    logic dir;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", longint'(ready_o), 0);
    chk("rst_done", longint'(done_o), 0);
    chk("rst_part1", longint'(part1_o), 0);
    chk("rst_part2", longint'(part2_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", longint'(ready_o), 0);

    // T1 puzzle example
    total_num_turns_i = 16'd10;
    do_init();
    chk("t1_ready_after_init", longint'(ready_o), 1);
    push_exp(3, 6);
    send(rot_l(68)); send(rot_l(30)); send(rot_r(48)); send(rot_l(5));
    send(rot_r(60)); send(rot_l(55)); send(rot_l(1));  send(rot_l(99));
    send(rot_r(14)); send(rot_l(82));
    wait_done("t1_done");
    chk("t1_done_ready", longint'(ready_o), 0);
    chk("t1_done_held", longint'(done_o), 1);

    // T2 multi-lap latency: R1000 then L50 proves pos returned to 50
    total_num_turns_i = 16'd2;
    do_init();
    chk("t2_done_cleared", longint'(done_o), 0);
    push_exp(1, 11);
    send(rot_r(1000));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready_o && lat < 500);
    chk("t2_latency", lat, 12);
    chk("t2_part2_laps", longint'(part2_o), 10);
    send(rot_l(50));
    wait_done("t2_done");

    // T3 boundary: L50, L0, R100 all end on 0
    total_num_turns_i = 16'd3;
    do_init();
    push_exp(3, 2);
    send(rot_l(50)); send(rot_l(0)); send(rot_r(100));
    wait_done("t3_done");

    // T4 leaving 0 to the left does not click
    total_num_turns_i = 16'd2;
    do_init();
    push_exp(1, 1);
    send(rot_l(50)); send(rot_l(5));
    wait_done("t4_done");

    // T5 random words with idle gaps, checked against a click-by-click model
    total_num_turns_i = 16'd20;
    pos = 50; p1 = 0; p2 = 0;
    for (int i = 0; i < 20; i++) begin
      d   = int'($urandom_range(0, 350));
      dir = 1'($urandom_range(0, 1));
      t5_words.push_back(dir ? rot_l(d) : rot_r(d));
      for (int k = 0; k < d; k++) begin
        pos = dir ? (pos + 99) % 100 : (pos + 1) % 100;
        if (pos == 0) p2++;
      end
      if (pos == 0) p1++;
    end
    do_init();
    push_exp(p1, p2);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(t5_words[i]);
    end
    wait_done("t5_done");

    // T6a abort mid-REDUCE with init_i
    total_num_turns_i = 16'd1;
    do_init();
    send(rot_r(1000));
    repeat (4) @(negedge clk);
    do_init();
    chk("t6_abort_ready", longint'(ready_o), 1);
    chk("t6_abort_part2", longint'(part2_o), 0);
    push_exp(1, 1);
    send(rot_l(50));
    wait_done("t6a_done");

    // T6b asynchronous reset mid-run
    total_num_turns_i = 16'd3;
    do_init();
    send(rot_r(10));
    send(rot_l(5));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", longint'(ready_o), 0);
    chk("t6_rst_done", longint'(done_o), 0);
    chk("t6_rst_part1", longint'(part1_o), 0);
    chk("t6_rst_part2", longint'(part2_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_ready", longint'(ready_o), 0);
    total_num_turns_i = 16'd1;
    do_init();
    chk("t6_init_ready", longint'(ready_o), 1);
    push_exp(1, 1);
    send(rot_l(50));
    wait_done("t6b_done");

    repeat (2) @(negedge clk);
    chk("sb_drained", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
